// File: rtl/keyboard_pkg.sv
// Shared constants and the ASCII key decoder for the keyboard command queue.
package keyboard_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [7:0] ASCII_W_UP = 8'h57;
  localparam logic [7:0] ASCII_W_LO = 8'h77;
  localparam logic [7:0] ASCII_S_UP = 8'h53;
  localparam logic [7:0] ASCII_S_LO = 8'h73;
  localparam logic [7:0] ASCII_A_UP = 8'h41;
  localparam logic [7:0] ASCII_A_LO = 8'h61;
  localparam logic [7:0] ASCII_D_UP = 8'h44;
  localparam logic [7:0] ASCII_D_LO = 8'h64;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_P_UP = 8'h50;
  localparam logic [7:0] ASCII_P_LO = 8'h70;
  localparam logic [7:0] ASCII_ESC  = 8'h1B;

  typedef struct packed {
    logic       is_dir;
    logic [1:0] dir;
    logic       is_start;
    logic       is_pause;
    logic       is_flush;
  } key_evt_t;

  // Map one received byte to at most one key event; unknown bytes map to nothing.
  function automatic key_evt_t decode_key(input logic [7:0] b);
    key_evt_t e;
    e = '0;
    case (b)
      ASCII_W_UP, ASCII_W_LO: begin e.is_dir = 1'b1; e.dir = DIR_UP;    end
      ASCII_S_UP, ASCII_S_LO: begin e.is_dir = 1'b1; e.dir = DIR_DOWN;  end
      ASCII_A_UP, ASCII_A_LO: begin e.is_dir = 1'b1; e.dir = DIR_LEFT;  end
      ASCII_D_UP, ASCII_D_LO: begin e.is_dir = 1'b1; e.dir = DIR_RIGHT; end
      ASCII_CR, ASCII_LF:     e.is_start = 1'b1;
      ASCII_P_UP, ASCII_P_LO: e.is_pause = 1'b1;
      ASCII_ESC:              e.is_flush = 1'b1;
      default:                e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/keyboard_cmd_queue_cmd_fifo.sv
// Synchronous FIFO with separate fill count; head is presented only once stored.
module cmd_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok_s, push_ok_s;

  assign empty_o   = (count_q == CW'(0));
  assign full_o    = (count_q == CW'(DEPTH));
  assign count_o   = count_q;
  assign data_o    = empty_o ? '0 : mem_q[rd_q];
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);

  // Next pointer/count values; flush overrides any same-cycle pop.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok_s) wr_d = wr_q + 1'b1;
      else           wr_d = wr_q;
      if (pop_ok_s)  rd_d = rd_q + 1'b1;
      else           rd_d = rd_q;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are only visible through counted entries, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/keyboard_cmd_queue.sv
// Keyboard byte decoder feeding a direction turn queue, plus held direction,
// pause, start and flush control for the game FSM.
module keyboard_cmd_queue
  import keyboard_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 25000000,
  parameter int DROP_REPEAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 uart_data,
  input  logic                       uart_valid,
  output logic [1:0]                 cmd_dir,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [$clog2(DEPTH+1)-1:0] cmd_count,
  output logic [1:0]                 held_dir,
  output logic                       held_valid,
  output logic                       start_game,
  output logic                       paused,
  output logic                       overflow
);

  localparam int              CW        = $clog2(DEPTH+1);
  localparam int              HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);

  key_evt_t      evt_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [1:0]    head_s;
  logic          pop_s, dir_key_s, repeat_s, push_s, ovf_s;

  logic [1:0]    held_dir_q, held_dir_d, last_dir_q, last_dir_d;
  logic          held_valid_q, held_valid_d, last_valid_q, last_valid_d;
  logic          paused_q, paused_d, start_q, start_d, ovf_q, ovf_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // Decode the byte and derive queue control for this cycle.
  always_comb begin
    if (uart_valid) evt_s = decode_key(uart_data);
    else            evt_s = '0;
    pop_s     = cmd_ready & ~fifo_empty_s;
    dir_key_s = evt_s.is_dir & ~paused_q;
    repeat_s  = (DROP_REPEAT != 0) && last_valid_q && (evt_s.dir == last_dir_q);
    push_s    = dir_key_s & ~repeat_s & (~fifo_full_s | pop_s);
    ovf_s     = dir_key_s & ~repeat_s & fifo_full_s & ~pop_s;
  end

  cmd_fifo #(.WIDTH(2), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_s),
    .data_i  (evt_s.dir),
    .pop_i   (pop_s),
    .flush_i (evt_s.is_flush),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  // Next state for held direction, hold timer, dedupe tracking, pause and pulses.
  always_comb begin
    held_dir_d   = held_dir_q;
    held_valid_d = held_valid_q;
    hold_cnt_d   = hold_cnt_q;
    last_dir_d   = last_dir_q;
    last_valid_d = last_valid_q;
    paused_d     = paused_q;
    start_d      = evt_s.is_start;
    ovf_d        = ovf_s;

    if (evt_s.is_flush) begin
      held_valid_d = 1'b0;
      hold_cnt_d   = '0;
      last_valid_d = 1'b0;
    end else if (dir_key_s) begin
      held_dir_d   = evt_s.dir;
      held_valid_d = 1'b1;
      hold_cnt_d   = '0;
      if (push_s) begin
        last_dir_d   = evt_s.dir;
        last_valid_d = 1'b1;
      end else begin
        last_dir_d   = last_dir_q;
      end
    end else if ((HOLD_CYCLES > 0) && held_valid_q && !paused_q) begin
      if (hold_cnt_q == HOLD_LAST) begin
        held_valid_d = 1'b0;
        hold_cnt_d   = '0;
      end else begin
        hold_cnt_d   = hold_cnt_q + HW'(1);
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end

    // Tracking of the last pushed entry ends when the queue drains by a pop.
    if (pop_s && !push_s && (fifo_count_s == CW'(1))) begin
      last_valid_d = 1'b0;
    end else begin
      last_valid_d = last_valid_d;
    end

    if (evt_s.is_start) begin
      paused_d = 1'b0;
    end else if (evt_s.is_pause) begin
      paused_d = ~paused_q;
    end else begin
      paused_d = paused_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      held_dir_q   <= 2'd0;
      held_valid_q <= 1'b0;
      hold_cnt_q   <= '0;
      last_dir_q   <= 2'd0;
      last_valid_q <= 1'b0;
      paused_q     <= 1'b0;
      start_q      <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      held_dir_q   <= held_dir_d;
      held_valid_q <= held_valid_d;
      hold_cnt_q   <= hold_cnt_d;
      last_dir_q   <= last_dir_d;
      last_valid_q <= last_valid_d;
      paused_q     <= paused_d;
      start_q      <= start_d;
      ovf_q        <= ovf_d;
    end
  end

  assign cmd_dir    = head_s;
  assign cmd_valid  = ~fifo_empty_s;
  assign cmd_count  = fifo_count_s;
  assign held_dir   = held_dir_q;
  assign held_valid = held_valid_q;
  assign start_game = start_q;
  assign paused     = paused_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_keyboard_cmd_queue.sv
// Scoreboard bench for keyboard_cmd_queue: a queue-based reference model runs at
// each rising edge, a monitor compares DUT outputs at each falling edge.
module tb_keyboard_cmd_queue;

  localparam int DEPTH = 4;
  localparam int HOLD  = 8;
  localparam int DROP  = 1;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    uart_data = 8'h00;
  logic          uart_valid = 1'b0;
  logic          cmd_ready = 1'b0;
  logic [1:0]    cmd_dir;
  logic          cmd_valid;
  logic [CW-1:0] cmd_count;
  logic [1:0]    held_dir;
  logic          held_valid;
  logic          start_game;
  logic          paused;
  logic          overflow;

  keyboard_cmd_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .DROP_REPEAT(DROP)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_data  (uart_data),
    .uart_valid (uart_valid),
    .cmd_dir    (cmd_dir),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_count  (cmd_count),
    .held_dir   (held_dir),
    .held_valid (held_valid),
    .start_game (start_game),
    .paused     (paused),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Reference model state
  int  exp_q[$];
  int  m_held_dir = 0, m_last_dir = 0, m_age = 0;
  bit  m_held_valid = 0, m_last_valid = 0, m_paused = 0;
  bit  m_start = 0, m_ovf = 0, m_dir_zero = 1;

  int  n_vec = 0;
  int  n_err = 0;

  // Direction of a byte (case-insensitive letter match), -1 if not a direction.
  function automatic int tb_dir(input logic [7:0] b);
    logic [7:0] c;
    c = (b >= 8'h41 && b <= 8'h5A) ? b + 8'h20 : b;
    if (c == 8'h77) return 0;
    if (c == 8'h73) return 1;
    if (c == 8'h61) return 2;
    if (c == 8'h64) return 3;
    return -1;
  endfunction

  // Reference model: applies the behavioural rules at every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        m_held_dir = 0; m_last_dir = 0; m_age = 0;
        m_held_valid = 0; m_last_valid = 0; m_paused = 0;
        m_start = 0; m_ovf = 0; m_dir_zero = 1;
      end else begin
        int d;
        bit pop, full, pushed;
        d      = uart_valid ? tb_dir(uart_data) : -1;
        m_start = 0;
        m_ovf   = 0;
        pushed  = 0;
        full    = (exp_q.size() == DEPTH);
        pop     = cmd_ready && (exp_q.size() != 0);
        if (pop) void'(exp_q.pop_front());
        if (uart_valid && uart_data == 8'h1B) begin
          exp_q.delete();
          m_last_valid = 0; m_held_valid = 0; m_age = 0;
        end else if (d >= 0 && !m_paused) begin
          m_held_dir = d; m_held_valid = 1; m_age = 0;
          if (DROP != 0 && m_last_valid && d == m_last_dir) begin
            pushed = 0;
          end else if (full && !pop) begin
            m_ovf = 1;
          end else begin
            exp_q.push_back(d);
            m_last_dir = d; m_last_valid = 1; pushed = 1; m_dir_zero = 0;
          end
        end else if (m_held_valid && !m_paused) begin
          if (m_age == HOLD - 1) m_held_valid = 0;
          else m_age = m_age + 1;
        end
        if (pop && !pushed && exp_q.size() == 0) m_last_valid = 0;
        if (uart_valid && (uart_data == 8'h0D || uart_data == 8'h0A)) begin
          m_start = 1; m_paused = 0;
        end else if (uart_valid && (uart_data == 8'h50 || uart_data == 8'h70)) begin
          m_paused = !m_paused;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs with the model away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmd_valid",  int'(cmd_valid),  int'(exp_q.size() != 0));
      chk("cmd_count",  int'(cmd_count),  exp_q.size());
      chk("held_valid", int'(held_valid), int'(m_held_valid));
      chk("held_dir",   int'(held_dir),   m_held_dir);
      chk("start_game", int'(start_game), int'(m_start));
      chk("paused",     int'(paused),     int'(m_paused));
      chk("overflow",   int'(overflow),   int'(m_ovf));
      if (exp_q.size() != 0) chk("cmd_dir", int'(cmd_dir), exp_q[0]);
      else if (m_dir_zero)   chk("cmd_dir_rst", int'(cmd_dir), 0);
    end
  end

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic cyc(input bit r, input bit v, input logic [7:0] d, input bit rdy);
    @(posedge clk);
    #2;
    rst = r; uart_valid = v; uart_data = d; cmd_ready = rdy;
  endtask

  task automatic key(input logic [7:0] d, input bit rdy);
    cyc(1'b0, 1'b1, d, rdy);
    cyc(1'b0, 1'b0, 8'h00, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, rdy);
  endtask

  logic [7:0] tbl [16];

  initial begin
    tbl = '{8'h77, 8'h57, 8'h73, 8'h53, 8'h61, 8'h41, 8'h64, 8'h44,
            8'h0D, 8'h0A, 8'h70, 8'h50, 8'h1B, 8'h77, 8'h61, 8'h64};
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    idle(2, 1'b0);
    // Three directions queued, then drained in order
    key(8'h77, 1'b0); key(8'h64, 1'b0); key(8'h73, 1'b0);
    idle(2, 1'b0);
    idle(5, 1'b1);
    // Overflow on fifth byte with no pop, then the same with a pop
    cyc(1'b0, 1'b1, 8'h61, 1'b0); cyc(1'b0, 1'b1, 8'h64, 1'b0);
    cyc(1'b0, 1'b1, 8'h61, 1'b0); cyc(1'b0, 1'b1, 8'h64, 1'b0);
    cyc(1'b0, 1'b1, 8'h61, 1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);
    cyc(1'b0, 1'b1, 8'h61, 1'b0); cyc(1'b0, 1'b1, 8'h64, 1'b0);
    cyc(1'b0, 1'b1, 8'h61, 1'b0); cyc(1'b0, 1'b1, 8'h64, 1'b0);
    cyc(1'b0, 1'b1, 8'h61, 1'b1);
    idle(2, 1'b0);
    idle(6, 1'b1);
    // Repeat drop, drain, same key accepted again
    key(8'h77, 1'b0); key(8'h57, 1'b0);
    idle(3, 1'b1);
    key(8'h77, 1'b0);
    idle(2, 1'b1);
    // Hold timeout, then refresh on the last cycle
    cyc(1'b0, 1'b1, 8'h64, 1'b1);
    idle(12, 1'b1);
    cyc(1'b0, 1'b1, 8'h73, 1'b1);
    idle(7, 1'b1);
    cyc(1'b0, 1'b1, 8'h73, 1'b1);
    idle(10, 1'b1);
    // Pause blocks direction keys; Enter resumes
    key(8'h70, 1'b0); key(8'h77, 1'b0);
    key(8'h0D, 1'b0);
    idle(2, 1'b1);
    // Flush, then reset with entries queued
    key(8'h77, 1'b0); key(8'h61, 1'b0); key(8'h73, 1'b0);
    key(8'h1B, 1'b0);
    key(8'h64, 1'b0); key(8'h77, 1'b0); key(8'h61, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    idle(3, 1'b0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, v, rdy;
      logic [7:0] b;
      int sel;
      r   = ($urandom_range(0, 399) == 0);
      v   = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 19);
      if (sel < 16) b = tbl[sel];
      else          b = 8'($urandom);
      if (i < 1500) rdy = ($urandom_range(0, 3) == 0);
      else          rdy = ($urandom_range(0, 3) != 0);
      cyc(r, v, b, rdy);
    end
    idle(3, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
